// File: rtl/handshake_const_arbiter_pkg.sv
// ============================================================================
// Module : handshake_const_arbiter_pkg
// Brief  : Shared constants and helpers for the constant-token arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package handshake_const_arbiter_pkg;

    localparam int unsigned c_buf_depth_base = 1;
    localparam int unsigned c_buf_depth_skid = 2;

    localparam int unsigned c_default_data_width = 37;
    localparam int unsigned c_default_num_req    = 4;

    // Slice 0 (least significant) belongs to requester 0.
    localparam logic [c_default_num_req*c_default_data_width-1:0] c_default_const_table =
        {37'h3, 37'h2, 37'h1, 37'h0E186ABA8A};

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/handshake_rr_picker.sv
// ============================================================================
// Module : handshake_rr_picker
// Brief  : Round-robin picker; first asserted request at or after i_ptr wins.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module handshake_rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx
);

    logic [2*NUM_REQ-1:0] w_req2;
    logic [NUM_REQ-1:0]   w_rot;
    logic [IDX_W:0]       w_sum;
    logic                 w_found;

    // Doubling the vector turns the wrap-around search into a plain rotate.
    always_comb begin
        w_req2  = {i_req, i_req};
        w_rot   = w_req2[i_ptr +: NUM_REQ];
        w_found = 1'b0;
        w_sum   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && w_rot[j]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, i_ptr} + (IDX_W+1)'(j);
            end
        end
        if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
            w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
        end
        o_idx   = w_sum[IDX_W-1:0];
        o_grant = w_found ? (NUM_REQ'(1) << w_sum[IDX_W-1:0]) : '0;
    end

endmodule

`default_nettype wire

// File: rtl/handshake_const_arbiter.sv
// ============================================================================
// Module : handshake_const_arbiter
// Brief  : Round-robin arbiter emitting each winner's constant token and id.
//          Define HANDSHAKE_CONST_ARBITER_SKID_EN for a 2-entry output buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module handshake_const_arbiter
    import handshake_const_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = c_default_data_width,
    parameter int unsigned NUM_REQ    = c_default_num_req,
    parameter logic [NUM_REQ*DATA_WIDTH-1:0] CONST_TABLE = c_default_const_table,
    localparam int unsigned ID_W = id_width(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    ctrl_valid,
    output logic [NUM_REQ-1:0]    ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic [ID_W-1:0]       outs_id,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    logic [ID_W-1:0]       r_rr_ptr;
    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_W-1:0]       w_idx;
    logic                  w_any;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_const;

    logic [DATA_WIDTH-1:0] r_outs;
    logic [ID_W-1:0]       r_id;

    handshake_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_picker (
        .i_req   (ctrl_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign w_any      = |ctrl_valid;
    assign w_const    = CONST_TABLE[w_idx*DATA_WIDTH +: DATA_WIDTH];
    assign w_pop      = outs_valid && outs_ready;
    assign w_push     = w_any && w_accept && !rst;
    assign ctrl_ready = (w_accept && !rst) ? w_grant : '0;
    assign outs       = r_outs;
    assign outs_id    = r_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_push) begin
            r_rr_ptr <= (w_idx == ID_W'(NUM_REQ-1)) ? '0 : w_idx + ID_W'(1);
        end
    end

`ifdef HANDSHAKE_CONST_ARBITER_SKID_EN
    // r_outs/r_id is the head entry; the skid slot only fills while the head stalls.
    logic [1:0]            r_count;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic [ID_W-1:0]       r_skid_id;

    assign w_accept   = (r_count != 2'(c_buf_depth_skid));
    assign outs_valid = (r_count != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_outs      <= '0;
            r_id        <= '0;
            r_skid_data <= '0;
            r_skid_id   <= '0;
        end else begin
            if (w_push && (r_count == 2'd0 || w_pop)) begin
                r_outs <= w_const;
                r_id   <= w_idx;
            end else if (w_push) begin
                r_skid_data <= w_const;
                r_skid_id   <= w_idx;
            end else if (w_pop && r_count == 2'd2) begin
                r_outs <= r_skid_data;
                r_id   <= r_skid_id;
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 2'd1;
            end
        end
    end
`else
    logic r_full;

    // A pop in the same cycle frees the single slot for the incoming token.
    assign w_accept   = !r_full || outs_ready;
    assign outs_valid = r_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_outs <= '0;
            r_id   <= '0;
        end else if (w_push) begin
            r_full <= 1'b1;
            r_outs <= w_const;
            r_id   <= w_idx;
        end else if (w_pop) begin
            r_full <= 1'b0;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_handshake_const_arbiter.sv
// ============================================================================
// Module : tb_handshake_const_arbiter
// Brief  : Self-checking bench with a queue-based token model and directed cases.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_handshake_const_arbiter;

`ifdef HANDSHAKE_CONST_ARBITER_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ctrl_valid = '0;
    logic [3:0]  ctrl_ready;
    logic [36:0] outs;
    logic [1:0]  outs_id;
    logic        outs_valid;
    logic        outs_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    handshake_const_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .ctrl_valid (ctrl_valid),
        .ctrl_ready (ctrl_ready),
        .outs       (outs),
        .outs_id    (outs_id),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [36:0] const_of(input int i);
        return (i == 0) ? 37'h0E186ABA8A : 37'(i);
    endfunction

    typedef struct {
        logic [36:0] d;
        logic [1:0]  id;
    } tok_t;

    tok_t        q[$];
    int          m_ptr    = 0;
    logic [36:0] m_last_d = '0;
    logic [1:0]  m_last_id = '0;
    bit          model_on = 1'b0;
    int          in_x  = 0;
    int          out_x = 0;
    int          waitc[N];

    // Inputs only change just after a rising edge, so the values seen here
    // are the ones the DUT samples at the next edge.
    always @(negedge clk) begin
        int   w;
        bit   can;
        logic [3:0] e_rdy;
        bit   e_v;
        if (model_on) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && ctrl_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            can   = (q.size() < DEPTH) || (DEPTH == 1 && outs_ready);
            e_rdy = (!rst && can && w >= 0) ? 4'(1 << w) : 4'b0;
            e_v   = (q.size() > 0);
            chk("ctrl_ready", 64'(ctrl_ready), 64'(e_rdy));
            chk("outs_valid", 64'(outs_valid), 64'(e_v));
            chk("outs", 64'(outs), 64'(e_v ? q[0].d : m_last_d));
            chk("outs_id", 64'(outs_id), 64'(e_v ? q[0].id : m_last_id));
            chk("onehot", 64'($countones(ctrl_ready) <= 1), 64'd1);

            if (rst) begin
                in_x = 0;
                out_x = 0;
                for (int i = 0; i < N; i++) waitc[i] = 0;
            end else begin
                if (|(ctrl_valid & ctrl_ready)) in_x++;
                if (outs_valid && outs_ready) out_x++;
                if (|(ctrl_valid & ctrl_ready)) begin
                    for (int i = 0; i < N; i++) begin
                        if (!ctrl_valid[i] || ctrl_ready[i]) waitc[i] = 0;
                        else waitc[i]++;
                    end
                    chk("no_starve", 64'(waitc[0] < N && waitc[1] < N && waitc[2] < N && waitc[3] < N), 64'd1);
                end else begin
                    for (int i = 0; i < N; i++) if (!ctrl_valid[i]) waitc[i] = 0;
                end
            end
        end

        if (rst) begin
            q.delete();
            m_ptr     = 0;
            m_last_d  = '0;
            m_last_id = '0;
            model_on  = 1'b1;
        end else if (model_on) begin
            if (e_v && outs_ready) void'(q.pop_front());
            if (e_rdy != 4'b0) begin
                q.push_back('{d: const_of(w), id: 2'(w)});
                m_last_d  = const_of(w);
                m_last_id = 2'(w);
                m_ptr     = (w + 1) % N;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [36:0] seq_d[5];
        int          seq_id[5];
        seq_d  = '{37'h0E186ABA8A, 37'h1, 37'h2, 37'h3, 37'h0E186ABA8A};
        seq_id = '{0, 1, 2, 3, 0};

        // Reset, with requests asserted during reset to confirm no grant.
        rst = 1'b1;
        tick();
        ctrl_valid = 4'b1111;
        tick();
        tick();
        rst = 1'b0;
        ctrl_valid = 4'b0001;
        outs_ready = 1'b1;
        chk("rst_outs_valid", 64'(outs_valid), 64'd0);
        chk("rst_outs", 64'(outs), 64'd0);
        chk("rst_outs_id", 64'(outs_id), 64'd0);
        tick();
        chk("single_outs", 64'(outs), 64'h0E186ABA8A);
        chk("single_id", 64'(outs_id), 64'd0);
        chk("single_valid", 64'(outs_valid), 64'd1);
        chk("single_rdy", 64'(ctrl_ready), 64'b0001);
        tick();
        chk("single_valid2", 64'(outs_valid), 64'd1);

        // All requesting: grants rotate 0,1,2,3,0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ctrl_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_id", 64'(outs_id), 64'(seq_id[i]));
            chk("rr_outs", 64'(outs), 64'(seq_d[i]));
        end

        // Drive pointer to 3, then only requester 0: wrap-around, pointer -> 1.
        tick();
        tick();
        ctrl_valid = 4'b0001;
        tick();
        chk("wrap_id", 64'(outs_id), 64'd0);
        ctrl_valid = 4'b1111;
        tick();
        chk("wrap_next_id", 64'(outs_id), 64'd1);

        // Backpressure with requesters 0 and 2.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ctrl_valid = 4'b0101;
        outs_ready = 1'b0;
        tick();
        chk("bp_id1", 64'(outs_id), 64'd0);
        chk("bp_valid1", 64'(outs_valid), 64'd1);
        chk("bp_rdy1", 64'(ctrl_ready), (DEPTH == 2) ? 64'b0100 : 64'b0000);
        tick();
        tick();
        chk("bp_id3", 64'(outs_id), 64'd0);
        chk("bp_outs3", 64'(outs), 64'h0E186ABA8A);
        chk("bp_rdy3", 64'(ctrl_ready), 64'b0000);
        outs_ready = 1'b1;
        #1;
        chk("bp_rdy_rel", 64'(ctrl_ready), (DEPTH == 2) ? 64'b0000 : 64'b0100);
        tick();
        chk("drain_id", 64'(outs_id), 64'd2);
        chk("drain_valid", 64'(outs_valid), 64'd1);
        ctrl_valid = 4'b0000;
        tick();
        chk("drained_valid", 64'(outs_valid), 64'd0);
        chk("hold_id", 64'(outs_id), 64'd2);
        chk("hold_outs", 64'(outs), 64'd2);

        // Reset with a token buffered and no downstream accept.
        ctrl_valid = 4'b0010;
        outs_ready = 1'b0;
        tick();
        chk("pre_rst_valid", 64'(outs_valid), 64'd1);
        rst = 1'b1;
        ctrl_valid = 4'b0000;
        tick();
        chk("mid_rst_valid", 64'(outs_valid), 64'd0);
        rst = 1'b0;
        ctrl_valid = 4'b1111;
        outs_ready = 1'b1;
        tick();
        chk("post_rst_id", 64'(outs_id), 64'd0);

        // Random traffic; requests change only occasionally so some are held.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 5) == 0) ctrl_valid = 4'($urandom_range(0, 15));
            outs_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        ctrl_valid = 4'b0000;
        outs_ready = 1'b0;
        tick();
        chk("conservation", 64'(in_x - out_x), 64'(q.size()));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/handshake_const_arbiter.md
HANDSHAKE_CONST_ARBITER -- requirements
Module: handshake_const_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 37, constant token width in bits.
REQ-002 Parameter NUM_REQ, default 4, number of requester control channels; legal range 2..16.
REQ-003 Parameter CONST_TABLE, default {37'h3, 37'h2, 37'h1, 37'h0E186ABA8A}, packed NUM_REQ*DATA_WIDTH bits; slice i is requester i's constant.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 ctrl_valid  input  NUM_REQ  per-requester token-request valid.
REQ-007 ctrl_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-008 outs  output  DATA_WIDTH  constant of the granted requester.
REQ-009 outs_id  output  clog2(NUM_REQ)  index of the requester that produced outs.
REQ-010 outs_valid  output  1  output token valid.
REQ-011 outs_ready  input  1  downstream accept.

Function
REQ-012 The block SHALL arbitrate round-robin among asserted ctrl_valid bits, starting the search at pointer rr_ptr and wrapping modulo NUM_REQ.
REQ-013 The block SHALL assert ctrl_ready[w] only for the winner w, and only when the output buffer can accept; input transfer = ctrl_valid[w] && ctrl_ready[w].
REQ-014 On input transfer, the block SHALL write {CONST_TABLE slice w, w} into the output buffer and set rr_ptr to (w+1) mod NUM_REQ; with no transfer, rr_ptr SHALL hold.
REQ-015 Latency from input transfer to outs_valid SHALL be exactly 1 cycle; there is no combinational path from ctrl_valid to outs_valid.
REQ-016 Output transfer = outs_valid && outs_ready; outs and outs_id SHALL stay stable while outs_valid && !outs_ready.
REQ-017 Baseline buffer (macro absent): one entry; accept = !full || outs_ready; simultaneous pop and push in one cycle SHALL replace the entry, giving one token per cycle.
REQ-018 ctrl_ready SHALL never depend on a requester's own ctrl_valid bit except through the arbitration choice; a deasserted requester SHALL never be granted.
REQ-019 With all ctrl_valid low, ctrl_ready SHALL be all zero and state SHALL be unchanged except for output pops.
REQ-020 outs and outs_id SHALL hold their last written value after a pop; only outs_valid drops.

Reset
REQ-021 While rst is high at a clock edge: outs_valid=0, outs=0, outs_id=0, rr_ptr=0, buffer count=0, and ctrl_ready=0 on the following cycle.
REQ-022 Reset mid-operation SHALL discard any buffered token without producing an output transfer.

Configuration
REQ-023 Macro HANDSHAKE_CONST_ARBITER_SKID_EN defined: the buffer SHALL be a 2-entry FIFO, accept = (count<2) from registered state only, no combinational outs_ready to ctrl_ready path; full throughput at count=1 with simultaneous push and pop.
REQ-024 Macro absent: the buffer SHALL be the 1-entry behaviour of REQ-017, and ctrl_ready SHALL depend combinationally on outs_ready.

Structure
REQ-025 A shared package SHALL hold the id-width function (clog2), the buffer-depth constants (1 and 2), and the default CONST_TABLE constant.
REQ-026 The round-robin picker SHALL be a sub-module, handshake_rr_picker (inputs req vector and pointer; outputs one-hot grant and index).

Verification
REQ-027 Reset, then ctrl_valid=4'b0001, outs_ready=1 -> next cycle outs=37'h0E186ABA8A, outs_id=0, outs_valid=1; one token per cycle while held.
REQ-028 ctrl_valid=4'b1111 held, outs_ready=1 -> grant order 0,1,2,3,0, with outs 37'h0E186ABA8A, 1, 2, 3, 37'h0E186ABA8A.
REQ-029 ctrl_valid=4'b0101, outs_ready=0 for 3 cycles -> one token (id 0) held stable in the baseline build (2 tokens, ids 0 and 2, with SKID_EN); ctrl_ready=0 once full; release -> id 0 then id 2 drained in order.
REQ-030 rr_ptr=3 and ctrl_valid=4'b0001 -> wrap-around grants id 0; next rr_ptr=1.
REQ-031 rst pulsed for 1 cycle with a token buffered and outs_ready=0 -> outs_valid=0 the next cycle, no transfer, next grant starts from id 0.
REQ-032 Random valid/ready for 10k cycles -> at most one ctrl_ready bit high per cycle, no starvation (each requester held valid is granted within NUM_REQ grants), and input transfers = output transfers + occupancy.
